shift_seq_ctrl: RTL and testbench

Command sequencer for the team's 4-bit universal shift register (ctrl 00 hold / 01 right / 10 left / 11 parallel load).
- Accepts one shift command over a valid/ready handshake.
- Drives the register's control, serial and parallel inputs to load an operand, then shifts it N times with the selected fill.
- Returns the register contents over a valid/ready result port.
- Sits between a requesting datapath and the shift register instance.

---
 rtl/shift_seq_pkg.sv | 37 +++
 rtl/shift_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift register command sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FILL_ZERO = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_ROT  = 2'd2,
        FILL_SIGN = 2'd3
    } fill_t;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_RIGHT = 2'b01;
    localparam logic [1:0] SR_LEFT  = 2'b10;
    localparam logic [1:0] SR_LOAD  = 2'b11;

    // Bit shifted into the register for a given fill mode and direction (dir 1 = left).
    function automatic logic fill_bit(input fill_t fill, input logic dir,
                                      input logic lsb, input logic msb);
        logic b;
        case (fill)
            FILL_ZERO: b = 1'b0;
            FILL_ONE:  b = 1'b1;
            FILL_ROT:  b = dir ? msb : lsb;
            FILL_SIGN: b = dir ? 1'b0 : msb;
            default:   b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the universal shift register: accepts a command,
// parallel-loads the operand, shifts it N times with the chosen fill and
// returns the register contents.
// Optional build macro SHIFT_SEQ_ABORT_EN adds an abort input that drops an
// in-flight command during LOAD or SHIFT.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_fill,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [1:0]       sr_ctrl,
    output logic             sr_serial_rs,
    output logic             sr_serial_ls,
    output logic [WIDTH-1:0] sr_parallel_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    state_t             r_state;
    logic               r_cmd_ready;
    logic [1:0]         r_sr_ctrl;
    logic [WIDTH-1:0]   r_sr_par;
    logic               r_res_valid;
    logic               r_busy;
    logic               r_dir;
    fill_t              r_fill;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_abort;
    logic               w_fill;
    logic [CNT_W-1:0]   w_count_clamped;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Shift counts beyond the register width are saturated to the width.
    assign w_count_clamped = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

    // Serial fill follows the live register contents while shifting.
    assign w_fill       = fill_bit(r_fill, r_dir, sr_q[0], sr_q[WIDTH-1]);
    assign sr_serial_rs = (r_state == SHIFT) && !r_dir && w_fill;
    assign sr_serial_ls = (r_state == SHIFT) &&  r_dir && w_fill;

    // The register holds in RESP, so its output is passed straight through.
    assign res_data = r_res_valid ? sr_q : '0;

    assign cmd_ready      = r_cmd_ready;
    assign sr_ctrl        = r_sr_ctrl;
    assign sr_parallel_in = r_sr_par;
    assign res_valid      = r_res_valid;
    assign busy           = r_busy;

    // Sequencer FSM; registered outputs are set for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_sr_ctrl   <= SR_HOLD;
            r_sr_par    <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_dir       <= 1'b0;
            r_fill      <= FILL_ZERO;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_state     <= LOAD;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_sr_ctrl   <= SR_LOAD;
                        r_sr_par    <= cmd_data;
                        r_dir       <= cmd_dir;
                        r_fill      <= fill_t'(cmd_fill);
                        r_cnt       <= w_count_clamped;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    r_sr_par <= '0;
                    if (w_abort) begin
                        r_state     <= IDLE;
                        r_sr_ctrl   <= SR_HOLD;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else if (r_cnt != '0) begin
                        r_state   <= SHIFT;
                        r_sr_ctrl <= r_dir ? SR_LEFT : SR_RIGHT;
                    end else begin
                        r_state     <= RESP;
                        r_sr_ctrl   <= SR_HOLD;
                        r_res_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_abort) begin
                        r_state     <= IDLE;
                        r_sr_ctrl   <= SR_HOLD;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state     <= RESP;
                            r_sr_ctrl   <= SR_HOLD;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_sr_ctrl <= SR_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl with a behavioural shift register attached.
module tb_shift_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data;
    logic          cmd_dir;
    logic [1:0]    cmd_fill;
    logic [CW-1:0] cmd_count;
    logic [1:0]    sr_ctrl;
    logic          sr_serial_rs;
    logic          sr_serial_ls;
    logic [W-1:0]  sr_parallel_in;
    logic [W-1:0]  sr_q;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  res_data;
    logic          busy;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_dir       (cmd_dir),
        .cmd_fill      (cmd_fill),
        .cmd_count     (cmd_count),
        .sr_ctrl       (sr_ctrl),
        .sr_serial_rs  (sr_serial_rs),
        .sr_serial_ls  (sr_serial_ls),
        .sr_parallel_in(sr_parallel_in),
        .sr_q          (sr_q),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy)
    );

    // Universal shift register model (reset tied to the same rst).
    always @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else begin
            case (sr_ctrl)
                2'b01:   sr_q <= {sr_serial_rs, sr_q[W-1:1]};
                2'b10:   sr_q <= {sr_q[W-2:0], sr_serial_ls};
                2'b11:   sr_q <= sr_parallel_in;
                default: sr_q <= sr_q;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] data;
        int           t;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference result: apply the fill/shift rules arithmetically.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input logic dir,
                                                input logic [1:0] fill, input int cnt);
        int v;
        int n;
        int f;
        v = int'(d);
        n = (cnt > W) ? W : cnt;
        for (int i = 0; i < n; i++) begin
            case (fill)
                2'd0:    f = 0;
                2'd1:    f = 1;
                2'd2:    f = dir ? ((v >> (W - 1)) & 1) : (v & 1);
                default: f = dir ? 0 : ((v >> (W - 1)) & 1);
            endcase
            if (dir) v = ((v << 1) | f) & ((1 << W) - 1);
            else     v = (v >> 1) | (f << (W - 1));
        end
        return W'(v);
    endfunction

    // Monitor: pops the scoreboard on each new result and checks the response port.
    logic         in_resp = 1'b0;
    logic [W-1:0] held;
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            in_resp = 1'b0;
        end else begin
            if (res_valid) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_result: got res_valid=1 data %0h, required no result (cycle %0d)", res_data, cyc);
                    end else begin
                        e = q.pop_front();
                        check("res_data", 32'(res_data), 32'(e.data));
                        check("res_latency", 32'(cyc - e.t), 32'(e.lat));
                    end
                    in_resp = 1'b1;
                    held    = res_data;
                end else begin
                    check("res_stable", 32'(res_data), 32'(held));
                end
                check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
                check("busy_in_resp", 32'(busy), 32'd1);
                if (res_ready) in_resp = 1'b0;
            end
            if (sr_ctrl != 2'b11) check("par_idle_zero", 32'(sr_parallel_in), 32'd0);
            if (sr_ctrl != 2'b01) check("rs_idle_zero", 32'(sr_serial_rs), 32'd0);
            if (sr_ctrl != 2'b10) check("ls_idle_zero", 32'(sr_serial_ls), 32'd0);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic dir, input logic [1:0] fill,
                        input logic [CW-1:0] cnt);
        exp_t e;
        int   n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_fill  = fill;
        cmd_count = cnt;
        for (int i = 0; i < 200; i++) begin
            if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
            if (cmd_ready) begin
                n      = (int'(cnt) > W) ? W : int'(cnt);
                e.data = ref_result(d, dir, fill, int'(cnt));
                e.t    = cyc;
                e.lat  = 2 + n;
                q.push_back(e);
                @(negedge clk);
                cmd_valid = 1'b0;
                cmd_data  = W'($urandom);
                cmd_dir   = 1'($urandom);
                cmd_fill  = 2'($urandom);
                cmd_count = CW'($urandom);
                return;
            end
            @(negedge clk);
        end
        checks++;
        $display("FAIL cmd_accept_timeout: got no cmd_ready in 200 cycles, required acceptance");
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
            #2;
            if (q.size() == 0 && !res_valid && cmd_ready) return;
        end
        checks++;
        $display("FAIL idle_timeout: got pending=%0d res_valid=%0b, required drained", q.size(), res_valid);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_dir   = 1'b0;
        cmd_fill  = 2'd0;
        cmd_count = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_sr_ctrl", 32'(sr_ctrl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed cases from the test plan.
        send(4'b1011, 1'b0, 2'd0, 3'd2);
        wait_idle(50);
        send(4'b1001, 1'b1, 2'd2, 3'd1);
        wait_idle(50);
        send(4'b1000, 1'b0, 2'd3, 3'd3);
        wait_idle(50);
        send(4'b0110, 1'b0, 2'd0, 3'd0);
        wait_idle(50);
        send(4'b0000, 1'b1, 2'd1, 3'd7);
        wait_idle(50);

        // Result stall with an ignored command pulse.
        res_ready = 1'b0;
        send(4'b0101, 1'b1, 2'd3, 3'd2);
        for (int i = 0; i < 20 && !res_valid; i++) begin
            @(negedge clk);
            #2;
        end
        check("stall_res_valid_seen", 32'(res_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = (i == 1 || i == 2);
            cmd_data  = W'($urandom);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        #2;
        check("stall_release_cmd_ready", 32'(cmd_ready), 32'd1);
        check("stall_release_res_valid", 32'(res_valid), 32'd0);
        check("stall_release_busy", 32'(busy), 32'd0);
        wait_idle(20);

        // Randomised commands with random result back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(W'($urandom), 1'($urandom), 2'($urandom), CW'($urandom_range(0, 7)));
        end
        wait_idle(200);
        rand_ready = 1'b0;
        res_ready  = 1'b1;

        // Reset in the middle of a shift drops the command.
        send(4'b1010, 1'b0, 2'd0, 3'd4);
        @(negedge clk);
        @(negedge clk);
        #2;
        check("mid_shift_sr_ctrl", 32'(sr_ctrl), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_sr_ctrl", 32'(sr_ctrl), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clk);
        send(4'b0011, 1'b1, 2'd2, 3'd3);
        wait_idle(50);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
